// File: rtl/alu_seq_nbit_if.sv
// Operand/result bundle between the control unit and the sequential ALU.
// The control unit drives the master side; the ALU implements the slave side.
interface alu_seq_nbit_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             busy;
  logic             done;
  logic             carry_flag;
  logic             zero_flag;
  logic             sign_flag;
  logic             ovf_flag;
  logic             err_flag;

  modport master (
    output start, op, a, b,
    input  result_lo, result_hi, busy, done,
    input  carry_flag, zero_flag, sign_flag, ovf_flag, err_flag
  );

  modport slave (
    input  start, op, a, b,
    output result_lo, result_hi, busy, done,
    output carry_flag, zero_flag, sign_flag, ovf_flag, err_flag
  );
endinterface

// File: rtl/alu_seq_nbit.sv
// Sequential N-bit ALU: 1-cycle logic/arith ops, multi-cycle shift-add MUL and
// restoring DIV. Define ALU_SEQ_DIV_EN to build the divider; otherwise op 110 is reserved.
module alu_seq_nbit #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          reset_n,
  alu_seq_nbit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [2:0] OP_DIV = 3'b110;
`endif

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             start_iter;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  logic             sub;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH-1:0] nxt_hi;
  logic             nxt_c;
  logic             nxt_z;
  logic             nxt_s;
  logic             nxt_o;
  logic             nxt_e;

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_diff;

  assign start_iter = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b != '0));
  assign div_shift  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ok     = (div_shift >= {1'b0, b_q});
  assign div_diff   = div_shift[WIDTH-1:0] - b_q;
`else
  assign start_iter = (bus.op == OP_MUL);
`endif

  // acc_hi/acc_lo hold partial product (MUL) or remainder/quotient (DIV)
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    if (op_q == OP_DIV) begin
      step_hi = div_ok ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ok};
    end
`endif
  end

  // Final result and flag selection, loaded into the output registers in FIN
  always_comb begin
    sub      = (op_q == OP_SUB);
    b_x      = b_q ^ {WIDTH{sub}};
    add_full = {1'b0, a_q} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
    nxt_lo   = '0;
    nxt_hi   = '0;
    nxt_c    = 1'b0;
    nxt_z    = 1'b0;
    nxt_s    = 1'b0;
    nxt_o    = 1'b0;
    nxt_e    = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        nxt_lo = add_full[WIDTH-1:0];
        nxt_c  = add_full[WIDTH];
        nxt_s  = add_full[WIDTH-1];
        nxt_o  = (a_q[WIDTH-1] == b_x[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);
        nxt_z  = (add_full[WIDTH-1:0] == '0);
      end
      OP_AND: begin
        nxt_lo = a_q & b_q;
        nxt_z  = ((a_q & b_q) == '0);
      end
      OP_OR: begin
        nxt_lo = a_q | b_q;
        nxt_z  = ((a_q | b_q) == '0);
      end
      OP_XOR: begin
        nxt_lo = a_q ^ b_q;
        nxt_z  = ((a_q ^ b_q) == '0);
      end
      OP_MUL: begin
        nxt_lo = acc_lo;
        nxt_hi = acc_hi;
        nxt_z  = ({acc_hi, acc_lo} == '0);
      end
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin
        if (b_q == '0) begin
          nxt_lo = '1;
          nxt_hi = a_q;
          nxt_e  = 1'b1;
        end else begin
          nxt_lo = acc_lo;
          nxt_hi = acc_hi;
          nxt_z  = (acc_lo == '0);
        end
      end
`endif
      default: begin
        nxt_z = 1'b1;
        nxt_e = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      acc_hi         <= '0;
      acc_lo         <= '0;
      bus.result_lo  <= '0;
      bus.result_hi  <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.carry_flag <= 1'b0;
      bus.zero_flag  <= 1'b0;
      bus.sign_flag  <= 1'b0;
      bus.ovf_flag   <= 1'b0;
      bus.err_flag   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            a_q    <= bus.a;
            b_q    <= bus.b;
            acc_hi <= '0;
            acc_lo <= bus.a;
            if (start_iter) begin
              state    <= RUN;
              cnt      <= CW'(WIDTH);
              bus.busy <= 1'b1;
            end else begin
              state <= FIN;
            end
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIN;
        end
        FIN: begin
          bus.result_lo  <= nxt_lo;
          bus.result_hi  <= nxt_hi;
          bus.carry_flag <= nxt_c;
          bus.zero_flag  <= nxt_z;
          bus.sign_flag  <= nxt_s;
          bus.ovf_flag   <= nxt_o;
          bus.err_flag   <= nxt_e;
          bus.done       <= 1'b1;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Self-checking bench for alu_seq_nbit (WIDTH=4): directed table, corner sequences,
// and random ops against an arithmetic reference model. Honours ALU_SEQ_DIV_EN.
module tb_alu_seq_nbit;

  localparam int W = 4;
  localparam int RW = 2 * W + 5;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         s;
    logic         o;
    logic         e;
  } res_t;

  typedef struct {
    logic [2:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t       exp;
  } vec_t;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  res_t last_exp;
  vec_t vecs[$];

  alu_seq_nbit_if #(.WIDTH(W)) bus ();

  alu_seq_nbit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic res_t mk_res(logic [W-1:0] lo, logic [W-1:0] hi,
                                  logic c, logic z, logic s, logic o, logic e);
    res_t r;
    r.lo = lo; r.hi = hi; r.c = c; r.z = z; r.s = s; r.o = o; r.e = e;
    return r;
  endfunction

  function automatic vec_t mk_vec(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, res_t r);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = r;
    return v;
  endfunction

  function automatic logic [RW-1:0] pack_res(res_t r);
    return {r.hi, r.lo, r.c, r.z, r.s, r.o, r.e};
  endfunction

  function automatic logic [RW-1:0] dut_res();
    return {bus.result_hi, bus.result_lo, bus.carry_flag, bus.zero_flag,
            bus.sign_flag, bus.ovf_flag, bus.err_flag};
  endfunction

  function automatic bit is_multi(logic [2:0] op, logic [W-1:0] b);
`ifdef ALU_SEQ_DIV_EN
    return (op == 3'd5) || ((op == 3'd6) && (b != '0));
`else
    return (op == 3'd5) && (b == b);
`endif
  endfunction

  // Arithmetic reference: integer math and signed range checks
  function automatic res_t model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    res_t   r;
    longint ua, ub, m, sa, sb, t, st;
    r  = mk_res('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ua = longint'(a);
    ub = longint'(b);
    m  = longint'(1) << W;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    case (op)
      3'd0, 3'd1: begin
        t    = (op == 3'd0) ? ua + ub : ua - ub;
        st   = (op == 3'd0) ? sa + sb : sa - sb;
        r.lo = W'(t);
        r.c  = (op == 3'd0) ? (t >= m) : (ua >= ub);
        r.o  = (st < -(m / 2)) || (st >= m / 2);
        r.s  = r.lo[W-1];
        r.z  = (r.lo == '0);
      end
      3'd2: begin r.lo = a & b; r.z = (r.lo == '0); end
      3'd3: begin r.lo = a | b; r.z = (r.lo == '0); end
      3'd4: begin r.lo = a ^ b; r.z = (r.lo == '0); end
      3'd5: begin
        t    = ua * ub;
        r.lo = W'(t);
        r.hi = W'(t >> W);
        r.z  = (t == 0);
      end
`ifdef ALU_SEQ_DIV_EN
      3'd6: begin
        if (ub == 0) begin
          r.lo = '1; r.hi = a; r.e = 1'b1;
        end else begin
          r.lo = W'(ua / ub);
          r.hi = W'(ua % ub);
          r.z  = ((ua / ub) == 0);
        end
      end
`endif
      default: begin r.z = 1'b1; r.e = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one op and checks handshake every cycle until done
  task automatic apply_stimulus(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input res_t exp,
                                input string name, input bit glitch);
    int lat;
    bit multi;
    multi = is_multi(op, b);
    lat   = multi ? W + 1 : 1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    for (int j = 0; j <= lat; j++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (j == 0) begin
        bus.a  = W'($urandom);
        bus.b  = W'($urandom);
        bus.op = 3'($urandom);
      end
      if (j == lat) break;
      @(negedge clk);
      if (j < lat - 0 && j + 1 < lat + 1 && j < lat) begin
        if (j + 1 < lat + 0 || j + 1 == lat) begin
        end
      end
      check_output({name, "/hs"}, {30'd0, bus.busy, bus.done}, {30'd0, multi, 1'b0});
      if (glitch && multi && (j == 1 || j == lat - 1)) begin
        bus.start = 1'b1;
        bus.op    = 3'd0;
      end
    end
    @(negedge clk);
    check_output({name, "/done"}, {30'd0, bus.busy, bus.done}, 32'd1);
    check_output({name, "/res"}, 32'(dut_res()), 32'(pack_res(exp)));
    last_exp = exp;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.op      = '0;
    bus.a       = '0;
    bus.b       = '0;

    vecs.push_back(mk_vec(3'd0, 4'h9, 4'h8, mk_res(4'h1, 4'h0, 1, 0, 0, 1, 0)));
    vecs.push_back(mk_vec(3'd1, 4'h5, 4'h5, mk_res(4'h0, 4'h0, 1, 1, 0, 0, 0)));
    vecs.push_back(mk_vec(3'd1, 4'h2, 4'h3, mk_res(4'hF, 4'h0, 0, 0, 1, 0, 0)));
    vecs.push_back(mk_vec(3'd5, 4'hF, 4'hF, mk_res(4'h1, 4'hE, 0, 0, 0, 0, 0)));
`ifdef ALU_SEQ_DIV_EN
    vecs.push_back(mk_vec(3'd6, 4'hD, 4'h3, mk_res(4'h4, 4'h1, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec(3'd6, 4'h7, 4'h0, mk_res(4'hF, 4'h7, 0, 0, 0, 0, 1)));
`else
    vecs.push_back(mk_vec(3'd6, 4'hD, 4'h3, mk_res(4'h0, 4'h0, 0, 1, 0, 0, 1)));
    vecs.push_back(mk_vec(3'd6, 4'h7, 4'h0, mk_res(4'h0, 4'h0, 0, 1, 0, 0, 1)));
`endif
    vecs.push_back(mk_vec(3'd7, 4'h5, 4'h3, mk_res(4'h0, 4'h0, 0, 1, 0, 0, 1)));
    vecs.push_back(mk_vec(3'd2, 4'hC, 4'hA, mk_res(4'h8, 4'h0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec(3'd3, 4'h0, 4'h0, mk_res(4'h0, 4'h0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk_vec(3'd4, 4'hF, 4'hF, mk_res(4'h0, 4'h0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk_vec(3'd0, 4'h7, 4'h1, mk_res(4'h8, 4'h0, 0, 0, 1, 1, 0)));
    vecs.push_back(mk_vec(3'd1, 4'h8, 4'h1, mk_res(4'h7, 4'h0, 1, 0, 0, 1, 0)));
    vecs.push_back(mk_vec(3'd5, 4'h0, 4'h9, mk_res(4'h0, 4'h0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk_vec(3'd5, 4'h3, 4'h5, mk_res(4'hF, 4'h0, 0, 0, 0, 0, 0)));

    repeat (2) @(negedge clk);
    check_output("reset", {17'd0, bus.busy, bus.done, 32'(dut_res())}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                     $sformatf("vec%0d", i), vecs[i].op == 3'd5);

    // Results must hold once done drops
    @(negedge clk);
    check_output("hold/hs", {30'd0, bus.busy, bus.done}, 32'd0);
    check_output("hold/res", 32'(dut_res()), 32'(pack_res(last_exp)));

    // Reset in the middle of a multiply aborts it with no done
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 4'hF; bus.b = 4'hF;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check_output("abort/reset", {17'd0, bus.busy, bus.done, 32'(dut_res())}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < W + 2; j++) begin
      @(negedge clk);
      check_output($sformatf("abort/idle%0d", j), {30'd0, bus.busy, bus.done}, 32'd0);
    end
    apply_stimulus(3'd0, 4'h1, 4'h1, mk_res(4'h2, 4'h0, 0, 0, 0, 0, 0), "abort/add", 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = (i % 8 == 0) ? '0 : W'($urandom);
      apply_stimulus(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d", i), i % 5 == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
